// File: rtl/seg_encoder.sv
// rtl/seg_encoder.sv - sequential binary-to-seven-segment encoder (double-dabble, three digits)
//
// Converts a signed calculator result (magnitude + sign) into a 24-bit,
// three-digit segment word for the display scanner. One double-dabble bit
// per clock; the output word only changes, all at once, in the MAP state.
//
// Optional feature macro: SEG_LZB_EN (leading-zero blanking). When undefined,
// all three digits are always shown.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-low reset
//   in_valid  result available on in_value/in_neg
//   in_ready  high while idle (decoded from state only)
//   in_value  unsigned magnitude, WIDTH bits
//   in_neg    result is negative
//   seg       {digit2, digit1, digit0}, each byte {dp,g,f,e,d,c,b,a}, active-high
//   done      one-cycle pulse when seg/ovf update
//   ovf       level; seg currently shows the "Err" pattern

module seg_encoder #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_value,
    input  logic             in_neg,
    output logic [23:0]      seg,
    output logic             done,
    output logic             ovf
);

    localparam logic [7:0]  SEG_BLANK = 8'h00;
    localparam logic [7:0]  SEG_MINUS = 8'h40;
    localparam logic [23:0] SEG_ERR   = 24'h795050;
    localparam logic [4:0]  LAST_STEP = 5'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] bin;
    logic [11:0]      bcd;
    logic [4:0]       cnt;
    logic             neg_q;
    logic             err_q;
    logic [23:0]      seg_word;

    function automatic logic [7:0] digit_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'h3F;
            4'd1:    c = 8'h06;
            4'd2:    c = 8'h5B;
            4'd3:    c = 8'h4F;
            4'd4:    c = 8'h66;
            4'd5:    c = 8'h6D;
            4'd6:    c = 8'h7D;
            4'd7:    c = 8'h07;
            4'd8:    c = 8'h7F;
            4'd9:    c = 8'h6F;
            default: c = SEG_BLANK;
        endcase
        return c;
    endfunction

    // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
    function automatic logic [11:0] dabble_adjust(input logic [11:0] b);
        logic [11:0] r;
        r = b;
        for (int i = 0; i < 3; i++) begin
            if (b[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = b[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == LAST_STEP) begin
                    state_next = MAP;
                end
            end
            MAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Segment word built from the finished BCD; only captured in MAP.
    always_comb begin
        logic       is_minus;
        logic [7:0] d2;
        logic [7:0] d1;
        logic [7:0] d0;
        // A zero magnitude never shows a minus sign.
        is_minus = neg_q && (bcd != 12'd0);
        d2 = is_minus ? SEG_MINUS : digit_code(bcd[11:8]);
        d1 = digit_code(bcd[7:4]);
        d0 = digit_code(bcd[3:0]);
`ifdef SEG_LZB_EN
        if (!is_minus && bcd[11:8] == 4'd0) begin
            d2 = SEG_BLANK;
        end
        if (bcd[11:4] == 8'd0) begin
            d1 = SEG_BLANK;
        end
`else
`endif
        seg_word = err_q ? SEG_ERR : {d2, d1, d0};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            err_q <= 1'b0;
            seg   <= '0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin   <= in_value;
                        bcd   <= '0;
                        cnt   <= '0;
                        neg_q <= in_neg;
                        // Only three digits (or sign + two) fit on the display.
                        err_q <= (32'(in_value) > 32'd999) ||
                                 (in_neg && (32'(in_value) > 32'd99));
                    end
                end
                SHIFT: begin
                    {bcd, bin} <= {dabble_adjust(bcd), bin} << 1;
                    cnt        <= cnt + 5'd1;
                end
                MAP: begin
                    seg  <= seg_word;
                    ovf  <= err_q;
                    done <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
